// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master: FSM states, mode encodings
// and the width of the transfer-length field.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  // SPI modes as {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Width of the len field: must hold NBITS itself, hence the +1.
  function automatic int spi_lenw(input int nbits);
    return $clog2(nbits) + 1;
  endfunction

endpackage

// File: rtl/spi_halfper_tick.sv
// Half-period timebase: a loadable down-counter that emits a one-cycle tick
// every div+1 clock cycles. While clr is high it keeps reloading div, so the
// first tick after clr drops arrives exactly div+1 cycles later.
module spi_halfper_tick #(
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [DIVW-1:0] div,
  output logic            tick
);

  logic [DIVW-1:0] cnt_q, cnt_d;

  assign tick = !clr && (cnt_q == '0);

  // Reload on clear or on every tick, otherwise count down towards zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = div;
    end else begin
      cnt_d = cnt_q - DIVW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_nb.sv
// SPI bus master with variable word length, run-time clock divider, all four
// CPOL/CPHA modes and one-hot active-low chip selects.
//
// Handshake: a transfer is accepted on any rising clk edge where start=1 and
// ready=1; ready stays low until the transfer completes. done pulses for one
// cycle together with the new dout value, and ready is already high in that
// same cycle, so a start held high is accepted on the done cycle.
//
// Timeline (H = div+1, L = clamped len, T = accept edge): SETUP for H cycles
// with sclk idle, then one sclk edge every H cycles (2L edges), then the
// remaining half-period plus HOLD keep sclk idle before csn is released.
module spi_master_nb
  import spi_pkg::*;
#(
  parameter  int NBITS = 32,
  parameter  int NCS   = 4,
  parameter  int DIVW  = 8,
  localparam int LENW  = spi_lenw(NBITS),
  localparam int CSW   = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [DIVW-1:0]  div,
  input  logic [LENW-1:0]  len,
  input  logic [CSW-1:0]   cs_sel,
  input  logic [NBITS-1:0] din,
  input  logic             start,
  output logic             ready,
  output logic             done,
  output logic [NBITS-1:0] dout,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic [NCS-1:0]   csn,
  output logic [1:0]       dbg_state
);

  spi_state_e       state_q, state_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic [DIVW-1:0]  div_q, div_d;
  logic [LENW-1:0]  len_q, len_d;
  logic [NBITS-1:0] tx_q, tx_d;
  logic [NBITS-1:0] rx_q, rx_d;
  logic [NBITS-1:0] dout_q, dout_d;
  logic [LENW:0]    edge_q, edge_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             done_q, done_d;
  logic [NCS-1:0]   csn_q, csn_d;

  logic             tick;
  logic [DIVW-1:0]  div_load;
  logic [LENW-1:0]  len_c;
  logic [NCS-1:0]   cs_dec;
  logic [LENW:0]    last_edge;
  logic [LENW:0]    edge_n;
  logic             edge_ev;
  logic             sample_ev;
  logic             drive_ev;

  // While idle the timebase loads the live div input so the first tick
  // after acceptance already uses the newly latched divider.
  assign div_load = (state_q == ST_IDLE) ? div : div_q;

  spi_halfper_tick #(
    .DIVW (DIVW)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == ST_IDLE),
    .div  (div_load),
    .tick (tick)
  );

  // Length clamp and chip-select decode of the live inputs
  always_comb begin
    len_c = len;
    if ((len == '0) || (len > LENW'(NBITS))) begin
      len_c = LENW'(NBITS);
    end
    cs_dec = '1;
    for (int i = 0; i < NCS; i++) begin
      if (cs_sel == CSW'(i)) begin
        cs_dec[i] = 1'b0;
      end
    end
  end

  // Odd edges are leading, even edges trailing. In mode cpha=0 the sample is
  // on leading edges; cpha=1 samples on trailing ones. The driving edge is the
  // other one, except that cpha=0 does not shift after the final bit.
  assign last_edge = {len_q, 1'b0};
  assign edge_n    = edge_q + (LENW+1)'(1);
  assign edge_ev   = tick && ((state_q == ST_SETUP) ||
                              ((state_q == ST_XFER) && (edge_q != last_edge)));
  assign sample_ev = edge_ev && (edge_n[0] != cpha_q);
  assign drive_ev  = edge_ev && (edge_n[0] == cpha_q) && (edge_n != last_edge);

  // Next-state and datapath logic
  always_comb begin
    state_d = state_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    div_d   = div_q;
    len_d   = len_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    edge_d  = edge_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    csn_d   = csn_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        sclk_d = cpol;
        mosi_d = 1'b0;
        csn_d  = '1;
        if (start) begin
          state_d = ST_SETUP;
          cpol_d  = cpol;
          cpha_d  = cpha;
          div_d   = div;
          len_d   = len_c;
          csn_d   = cs_dec;
          edge_d  = '0;
          rx_d    = '0;
          // Left-align the word so the first bit to send sits at the MSB
          tx_d    = din << (LENW'(NBITS) - len_c);
          if (!cpha) begin
            mosi_d = tx_d[NBITS-1];
            tx_d   = {tx_d[NBITS-2:0], 1'b0};
          end
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (tick && (edge_q == last_edge)) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_IDLE;
          csn_d   = '1;
          done_d  = 1'b1;
          dout_d  = rx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (edge_ev) begin
      sclk_d = ~sclk_q;
      edge_d = edge_n;
    end
    if (sample_ev) begin
      rx_d = {rx_q[NBITS-2:0], miso};
    end
    if (drive_ev) begin
      mosi_d = tx_q[NBITS-1];
      tx_d   = {tx_q[NBITS-2:0], 1'b0};
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      div_q   <= '0;
      len_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      edge_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      csn_q   <= '1;
    end else begin
      state_q <= state_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      div_q   <= div_d;
      len_q   <= len_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      csn_q   <= csn_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign done      = done_q;
  assign dout      = dout_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign csn       = csn_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_master_nb.sv
// Bench for spi_master_nb: an SPI slave model that follows the selected
// mode, captures mosi and returns its own word on miso, plus a scoreboard
// of expected dout words and timing checks derived from H and L.
module tb_spi_master_nb;

  localparam int NBITS = 32;
  localparam int NCS   = 4;
  localparam int DIVW  = 8;
  localparam int LENW  = 6;
  localparam int CSW   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cpol, cpha, start;
  logic [DIVW-1:0]  div;
  logic [LENW-1:0]  len;
  logic [CSW-1:0]   cs_sel;
  logic [NBITS-1:0] din;
  logic             ready, done, sclk, mosi, miso;
  logic [NBITS-1:0] dout;
  logic [NCS-1:0]   csn;
  logic [1:0]       dbg_state;
  logic             miso_s, loop_en;

  int n_checks = 0;
  int n_errors = 0;
  logic [NBITS-1:0] exp_q[$];

  assign miso = loop_en ? mosi : miso_s;

  spi_master_nb #(.NBITS(NBITS), .NCS(NCS), .DIVW(DIVW)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .div(div), .len(len),
    .cs_sel(cs_sel), .din(din), .start(start), .ready(ready), .done(done),
    .dout(dout), .sclk(sclk), .mosi(mosi), .miso(miso), .csn(csn),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NBITS-1:0] mask_l(input int l);
    logic [NBITS-1:0] m;
    m = '0;
    for (int i = 0; i < l; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [NCS-1:0] exp_csn(input int cs);
    logic [NCS-1:0] v;
    v = '1;
    if (cs < NCS) v[cs] = 1'b0;
    return v;
  endfunction

  // One transfer: call at a negedge; returns at the negedge showing done.
  task automatic run_xfer(input string name, input bit cp, input bit ch,
                          input int dv, input int ln, input int cs,
                          input logic [NBITS-1:0] dw, input logic [NBITS-1:0] sw,
                          input bit loop, input bit hold);
    int l, h, t_done, n_edges, gap_bad, sclk_bad, csn_bad, csn_low;
    int ready_bad, done_cnt, done_cyc, sidx;
    logic [NBITS-1:0] got_mosi, dout_at_done;
    logic [NCS-1:0] ecsn;
    logic prev;
    bit lead;
    l = (ln == 0 || ln > NBITS) ? NBITS : ln;
    h = dv + 1;
    t_done = (2 * l + 2) * h;
    ecsn = exp_csn(cs);
    exp_q.push_back(sw & mask_l(l));
    n_edges = 0; gap_bad = 0; sclk_bad = 0; csn_bad = 0; csn_low = 0;
    ready_bad = 0; done_cnt = 0; done_cyc = -1; sidx = l - 1;
    got_mosi = '0; dout_at_done = '0; prev = cp;
    cpol = cp; cpha = ch; div = DIVW'(dv); len = LENW'(ln); cs_sel = CSW'(cs);
    din = dw; loop_en = loop; miso_s = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc <= t_done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        start = hold;
        if (!ch) begin
          miso_s = sw[sidx];
          sidx--;
        end
      end
      if (cyc == t_done / 2) begin
        cpol = 1'($urandom); cpha = 1'($urandom); div = DIVW'($urandom);
        len = LENW'($urandom); cs_sel = CSW'($urandom); din = $urandom;
      end
      if (csn != '1) csn_low++;
      if (cyc < t_done && csn !== ecsn) csn_bad++;
      if (cyc == t_done && csn !== '1) csn_bad++;
      if ((cyc < t_done) == (ready === 1'b1)) ready_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        dout_at_done = dout;
      end
      if ((cyc < h || cyc >= 2 * l * h) && sclk !== cp) sclk_bad++;
      if (sclk !== prev) begin
        n_edges++;
        if (cyc != n_edges * h) gap_bad++;
        lead = (sclk != cp);
        if (lead != ch) begin
          got_mosi = {got_mosi[NBITS-2:0], mosi};
        end else if (sidx >= 0) begin
          miso_s = sw[sidx];
          sidx--;
        end
        prev = sclk;
      end
    end
    check_eq($sformatf("%s_done_cyc", name), 64'(done_cyc), 64'(t_done));
    check_eq($sformatf("%s_done_cnt", name), 64'(done_cnt), 64'd1);
    check_eq($sformatf("%s_dout", name), 64'(dout_at_done), 64'(exp_q.pop_front()));
    check_eq($sformatf("%s_edges", name), 64'(n_edges), 64'(2 * l));
    check_eq($sformatf("%s_edge_time", name), 64'(gap_bad), 64'd0);
    check_eq($sformatf("%s_mosi", name), 64'(got_mosi), 64'(dw & mask_l(l)));
    check_eq($sformatf("%s_csn_val", name), 64'(csn_bad), 64'd0);
    check_eq($sformatf("%s_csn_low", name), 64'(csn_low), 64'((cs < NCS) ? t_done : 0));
    check_eq($sformatf("%s_ready", name), 64'(ready_bad), 64'd0);
    check_eq($sformatf("%s_sclk_idle", name), 64'(sclk_bad), 64'd0);
  endtask

  initial begin
    int dcnt;
    rst = 1'b1; start = 1'b0; cpol = 1'b1; cpha = 1'b0; div = '0; len = '0;
    cs_sel = '0; din = '0; miso_s = 1'b0; loop_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 64'(ready), 64'd1);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_dout", 64'(dout), 64'd0);
    check_eq("rst_sclk", 64'(sclk), 64'd0);
    check_eq("rst_mosi", 64'(mosi), 64'd0);
    check_eq("rst_csn", 64'(csn), 64'hF);
    check_eq("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_sclk_cpol1", 64'(sclk), 64'd1);
    cpol = 1'b0;
    @(negedge clk);
    check_eq("idle_sclk_cpol0", 64'(sclk), 64'd0);

    // Mode 0 loopback
    run_xfer("t1", 1'b0, 1'b0, 0, 8, 0, 32'hA5, 32'hA5, 1'b1, 1'b0);

    // All four modes, fixed words
    for (int m = 0; m < 4; m++)
      run_xfer($sformatf("t2m%0d", m), m[1], m[0], 3, 12, 1,
               32'h5C3, 32'h9E1, 1'b0, 1'b0);

    // Length clamping
    run_xfer("t3_len0", 1'b0, 1'b1, 1, 0, 3, $urandom, $urandom, 1'b0, 1'b0);
    run_xfer("t3_len40", 1'b1, 1'b0, 1, 40, 0, $urandom, $urandom, 1'b0, 1'b0);

    // Chip-select decode
    run_xfer("t4_cs2", 1'b0, 1'b0, 0, 6, 2, $urandom, $urandom, 1'b0, 1'b0);
    run_xfer("t4_cs3", 1'b1, 1'b1, 2, 5, 3, $urandom, $urandom, 1'b0, 1'b0);

    // start held high: one transfer, next one accepted on the done cycle
    run_xfer("t5_a", 1'b0, 1'b1, 1, 10, 1, 32'h2B7, 32'h1C4, 1'b0, 1'b1);
    run_xfer("t5_b", 1'b1, 1'b0, 0, 7, 0, 32'h55, 32'h3A, 1'b0, 1'b0);

    // Random transfers with random idle gaps
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_xfer($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 40)),
               int'($urandom_range(0, NCS - 1)), $urandom, $urandom,
               1'b0, 1'b0);
    end

    // Reset in the middle of a transfer
    cpol = 1'b1; cpha = 1'b0; div = DIVW'(1); len = LENW'(8); cs_sel = CSW'(2);
    din = 32'hC3; loop_en = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("t6_csn", 64'(csn), 64'hF);
    check_eq("t6_sclk", 64'(sclk), 64'd0);
    check_eq("t6_ready", 64'(ready), 64'd1);
    check_eq("t6_dout", 64'(dout), 64'd0);
    rst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    check_eq("t6_no_done", 64'(dcnt), 64'd0);
    check_eq("t6_dout_hold", 64'(dout), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
